// File: rtl/layer_serializer.sv
// Ping-pong buffered vector-to-word serializer between NN layers; optional argmax when LAYER_SER_ARGMAX_EN is defined.
// Latency: word 0 is presented the cycle after capture; one word per cycle while out_ready is high.
// Backpressure: out_ready stalls the stream with outputs held; in_ready drops while both slots are full, and further vectors are dropped (sticky overflow).
module layer_serializer #(
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = $clog2(NUM_NEURON)
) (
    input  logic                             s_axi_aclk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] in_data,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic [IDX_WIDTH-1:0]             out_idx,
    output logic                             overflow,
    output logic [IDX_WIDTH-1:0]             max_idx,
    output logic                             max_idx_vld
);
    // The state encoding doubles as the count of buffered vectors.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        SEND_PEND = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURON - 1);

    state_t                                state_q, state_d;
    logic                                  wr_ptr_q, rd_ptr_q;
    logic [IDX_WIDTH-1:0]                  idx_q;
    logic                                  overflow_q;
    logic [NUM_NEURON-1:0][DATA_WIDTH-1:0] slot_q [2];
    logic                                  capture, xfer, xfer_last;
    logic [DATA_WIDTH-1:0]                 cur_word;

    assign in_ready  = (state_q != SEND_PEND);
    assign out_valid = (state_q != IDLE);
    assign capture   = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign xfer_last = xfer && (idx_q == LAST_IDX);
    assign cur_word  = slot_q[rd_ptr_q][idx_q];
    // Slots are not reset, so mask the word while nothing is buffered.
    assign out_data  = out_valid ? cur_word : '0;
    assign out_last  = (idx_q == LAST_IDX);
    assign out_idx   = idx_q;
    assign overflow  = overflow_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (capture) state_d = SEND;
            end
            SEND: begin
                if (capture && !xfer_last)      state_d = SEND_PEND;
                else if (!capture && xfer_last) state_d = IDLE;
            end
            SEND_PEND: begin
                if (xfer_last) state_d = SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) wr_ptr_q <= ~wr_ptr_q;
            if (xfer_last) begin
                idx_q    <= '0;
                rd_ptr_q <= ~rd_ptr_q;
            end else if (xfer) begin
                idx_q <= idx_q + IDX_WIDTH'(1);
            end
            if (in_valid && !in_ready) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (capture) slot_q[wr_ptr_q] <= in_data;
    end

`ifdef LAYER_SER_ARGMAX_EN
    logic signed [DATA_WIDTH-1:0] run_max_q;
    logic [IDX_WIDTH-1:0]         run_idx_q;
    logic [IDX_WIDTH-1:0]         max_idx_q;
    logic                         max_vld_q;
    logic                         new_max;

    // Word 0 always seeds the running max; strict compare keeps the lowest index on ties.
    assign new_max = (idx_q == '0) || ($signed(cur_word) > run_max_q);

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            run_max_q <= '0;
            run_idx_q <= '0;
            max_idx_q <= '0;
            max_vld_q <= 1'b0;
        end else begin
            max_vld_q <= xfer_last;
            if (xfer && new_max) begin
                run_max_q <= cur_word;
                run_idx_q <= idx_q;
            end
            if (xfer_last) max_idx_q <= new_max ? idx_q : run_idx_q;
        end
    end

    assign max_idx     = max_idx_q;
    assign max_idx_vld = max_vld_q;
`else
    assign max_idx     = '0;
    assign max_idx_vld = 1'b0;
`endif

endmodule
